// File: rtl/pipelined_barrel_shifter_if.sv
// Valid/ready request and response bundle for pipelined_barrel_shifter.
// When SHIFT_WORD_OP_EN is defined, the bundle also carries in_word for the 32-bit W-variants.
interface pipelined_barrel_shifter_if #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned TAG_W = 5
);
  localparam int unsigned SHW = $clog2(XLEN);

  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  in_data;
  logic [SHW-1:0]   in_amt;
  logic [1:0]       in_op;
  logic [TAG_W-1:0] in_tag;
`ifdef SHIFT_WORD_OP_EN
  logic             in_word;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_data;
  logic [TAG_W-1:0] out_tag;

`ifdef SHIFT_WORD_OP_EN
  modport master (output in_valid, in_data, in_amt, in_op, in_tag, in_word, out_ready,
                  input  in_ready, out_valid, out_data, out_tag);
  modport slave  (input  in_valid, in_data, in_amt, in_op, in_tag, in_word, out_ready,
                  output in_ready, out_valid, out_data, out_tag);
`else
  modport master (output in_valid, in_data, in_amt, in_op, in_tag, out_ready,
                  input  in_ready, out_valid, out_data, out_tag);
  modport slave  (input  in_valid, in_data, in_amt, in_op, in_tag, out_ready,
                  output in_ready, out_valid, out_data, out_tag);
`endif
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// Fixed-latency pipelined barrel shifter (pass/SLL/SRL/SRA) with valid/ready and a sideband tag.
// Optional SHIFT_WORD_OP_EN adds the RV64 32-bit W-variants via in_word (XLEN must be 64).
module pipelined_barrel_shifter #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned STAGES = 2,
  parameter int unsigned TAG_W  = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  pipelined_barrel_shifter_if.slave bus
);
  localparam int unsigned SHW = $clog2(XLEN);
  localparam int unsigned L   = (SHW + STAGES - 1) / STAGES;

  typedef struct packed {
    logic [XLEN-1:0]  data;
    logic [SHW-1:0]   amt;
    logic [1:0]       op;
    logic             fill;
`ifdef SHIFT_WORD_OP_EN
    logic             word;
`endif
    logic [TAG_W-1:0] tag;
  } stage_t;

  if (STAGES == 0 || STAGES > SHW) begin : g_bad_stages
    $error("pipelined_barrel_shifter: STAGES must be in 1..$clog2(XLEN)");
  end
  if (XLEN < 8 || (XLEN & (XLEN - 1)) != 0) begin : g_bad_xlen
    $error("pipelined_barrel_shifter: XLEN must be a power of two >= 8");
  end
`ifdef SHIFT_WORD_OP_EN
  if (XLEN != 64) begin : g_bad_word_xlen
    $error("pipelined_barrel_shifter: SHIFT_WORD_OP_EN requires XLEN == 64");
  end
`endif

  logic              adv;
  logic              accept;
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] vld_d;
  stage_t            stg_in;
  stage_t            stg_d [STAGES];
  stage_t            stg_q [STAGES];

  // Single global stall: the whole pipe moves only when the output slot can drain.
  assign adv          = ~vld_q[STAGES-1] | bus.out_ready;
  assign accept       = bus.in_valid & adv;
  assign bus.in_ready = adv;

  // Operand capture; W-variants are reduced to a 64-bit problem whose low word is exact.
  always_comb begin
    stg_in      = '0;
    stg_in.data = bus.in_data;
    stg_in.amt  = bus.in_amt;
    stg_in.op   = bus.in_op;
    stg_in.fill = bus.in_data[XLEN-1];
    stg_in.tag  = bus.in_tag;
`ifdef SHIFT_WORD_OP_EN
    stg_in.word = bus.in_word;
    if (bus.in_word) begin
      stg_in.data = XLEN'({{32{(bus.in_op == 2'b11) & bus.in_data[31]}}, bus.in_data[31:0]});
      stg_in.amt  = SHW'({1'b0, bus.in_amt[4:0]});
      stg_in.fill = bus.in_data[31];
    end
`endif
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned LO = k * L;
    localparam int unsigned HI = ((k + 1) * L < SHW) ? (k + 1) * L : SHW;

    stage_t src;
    stage_t cur;

    if (k == 0) begin : g_first
      assign src = stg_in;
    end else begin : g_next
      assign src = stg_q[k-1];
    end

    // Shift levels 2^LO .. 2^(HI-1); SRA ORs the captured sign into the vacated MSBs.
    always_comb begin
      cur = src;
      for (int unsigned i = LO; i < HI; i++) begin
        if (src.amt[i]) begin
          case (src.op)
            2'b01:   cur.data = cur.data << (1 << i);
            2'b10:   cur.data = cur.data >> (1 << i);
            2'b11:   cur.data = (cur.data >> (1 << i)) |
                                ({XLEN{src.fill}} & ~({XLEN{1'b1}} >> (1 << i)));
            default: cur.data = cur.data;
          endcase
        end
      end
`ifdef SHIFT_WORD_OP_EN
      if (k == STAGES - 1 && cur.word) begin
        cur.data = XLEN'({{32{cur.data[31]}}, cur.data[31:0]});
      end
`endif
    end

    assign stg_d[k] = cur;
  end

  // Valid bits advance with the pipe; flush kills everything including a same-cycle accept.
  always_comb begin
    vld_d = vld_q;
    if (flush) begin
      vld_d = '0;
    end else if (adv) begin
      vld_d    = vld_q << 1;
      vld_d[0] = accept;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int k = 0; k < int'(STAGES); k++) stg_q[k] <= '0;
    end else begin
      vld_q <= vld_d;
      if (adv) begin
        for (int k = 0; k < int'(STAGES); k++) stg_q[k] <= stg_d[k];
      end
    end
  end

  assign bus.out_valid = vld_q[STAGES-1];
  assign bus.out_data  = stg_q[STAGES-1].data;
  assign bus.out_tag   = stg_q[STAGES-1].tag;
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench for pipelined_barrel_shifter (XLEN=64, STAGES=2): directed table,
// stall/flush/reset sequences and randomized traffic against a scoreboard model.
module tb_pipelined_barrel_shifter;
  localparam int unsigned XLEN   = 64;
  localparam int unsigned STAGES = 2;
  localparam int unsigned TAG_W  = 5;
  localparam int unsigned SHW    = $clog2(XLEN);

  localparam logic [1:0] OP_PASS = 2'b00;
  localparam logic [1:0] OP_SLL  = 2'b01;
  localparam logic [1:0] OP_SRL  = 2'b10;
  localparam logic [1:0] OP_SRA  = 2'b11;

  typedef struct {
    logic [XLEN-1:0] data;
    logic [SHW-1:0]  amt;
    logic [1:0]      op;
    logic            word;
    logic [XLEN-1:0] exp;
  } vec_t;

  typedef struct {
    logic [XLEN-1:0]  data;
    logic [TAG_W-1:0] tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  logic in_word_tb;

  int n_cmp  = 0;
  int n_fail = 0;

  exp_t             exp_q[$];
  logic [TAG_W-1:0] ret_tags[$];
  exp_t             e;

  pipelined_barrel_shifter_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

`ifdef SHIFT_WORD_OP_EN
  assign bus.in_word = in_word_tb;
`endif

  pipelined_barrel_shifter #(.XLEN(XLEN), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: RISC-V shift semantics in plain operators.
  function automatic logic [XLEN-1:0] model(input logic [XLEN-1:0] d, input logic [SHW-1:0] amt,
                                            input logic [1:0] op, input logic word);
    logic [XLEN-1:0] r;
    logic [31:0]     w;
    int unsigned     a;
    a = amt;
    r = d;
    if (word) begin
      w = d[31:0];
      case (op)
        OP_SLL:  w = w << (a % 32);
        OP_SRL:  w = w >> (a % 32);
        OP_SRA:  w = $unsigned($signed(w) >>> (a % 32));
        default: w = d[31:0];
      endcase
      r = {{32{w[31]}}, w};
    end else begin
      case (op)
        OP_SLL:  r = d << a;
        OP_SRL:  r = d >> a;
        OP_SRA:  r = $unsigned($signed(d) >>> a);
        default: r = d;
      endcase
    end
    return r;
  endfunction

  // Scoreboard: retire checked first, then flush drops everything outstanding, else accept enqueues.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (bus.out_valid && bus.out_ready && !flush) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL spurious_out: got tag %0d data %h with nothing outstanding", bus.out_tag, bus.out_data);
        end else begin
          e = exp_q.pop_front();
          chk("sb_data", bus.out_data, e.data);
          chk("sb_tag", XLEN'(bus.out_tag), XLEN'(e.tag));
          ret_tags.push_back(bus.out_tag);
        end
      end
      if (flush) begin
        exp_q.delete();
      end else if (bus.in_valid && bus.in_ready) begin
        e.data = model(bus.in_data, bus.in_amt, bus.in_op, in_word_tb);
        e.tag  = bus.in_tag;
        exp_q.push_back(e);
      end
    end
  end

  task automatic send(input logic [XLEN-1:0] d, input logic [SHW-1:0] a, input logic [1:0] op,
                      input logic [TAG_W-1:0] tag, input logic word);
    bit acc;
    int guard;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_amt   = a;
    bus.in_op    = op;
    bus.in_tag   = tag;
    in_word_tb   = word;
    acc   = 1'b0;
    guard = 0;
    while (!acc) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      guard++;
      if (!acc && guard > 200) begin
        n_cmp++;
        n_fail++;
        $display("FAIL send_timeout: tag %0d never accepted", tag);
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  vec_t vecs[$];
  vec_t v;
  bit   done;
  int   t;
  logic [XLEN-1:0]  hd;
  logic [TAG_W-1:0] ht;

  initial begin
    rst_n         = 1'b0;
    flush         = 1'b0;
    in_word_tb    = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_amt    = '0;
    bus.in_op     = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;

    // Directed table
    vecs.push_back('{64'h1, 6'd63, OP_SLL, 1'b0, 64'h8000_0000_0000_0000});
    vecs.push_back('{64'h8000_0000_0000_0000, 6'd63, OP_SRL, 1'b0, 64'h1});
    vecs.push_back('{64'h8000_0000_0000_0000, 6'd63, OP_SRA, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF});
    vecs.push_back('{64'hDEAD_BEEF_0123_4567, 6'd0, OP_SLL, 1'b0, 64'hDEAD_BEEF_0123_4567});
    vecs.push_back('{64'hDEAD_BEEF_0123_4567, 6'd0, OP_SRL, 1'b0, 64'hDEAD_BEEF_0123_4567});
    vecs.push_back('{64'hDEAD_BEEF_0123_4567, 6'd0, OP_SRA, 1'b0, 64'hDEAD_BEEF_0123_4567});
    vecs.push_back('{64'hDEAD_BEEF_0123_4567, 6'd17, OP_PASS, 1'b0, 64'hDEAD_BEEF_0123_4567});
    vecs.push_back('{64'hF000_0000_0000_0000, 6'd4, OP_SRA, 1'b0, 64'hFF00_0000_0000_0000});
    vecs.push_back('{64'h0123_4567_89AB_CDEF, 6'd8, OP_SLL, 1'b0, 64'h2345_6789_ABCD_EF00});
    vecs.push_back('{64'h0123_4567_89AB_CDEF, 6'd8, OP_SRL, 1'b0, 64'h0001_2345_6789_ABCD});
    vecs.push_back('{64'h7FFF_FFFF_FFFF_FFFF, 6'd62, OP_SRA, 1'b0, 64'h1});
    vecs.push_back('{64'h8000_0000_0000_0001, 6'd1, OP_SRA, 1'b0, 64'hC000_0000_0000_0000});
    vecs.push_back('{64'h0000_0000_FFFF_FFFF, 6'd32, OP_SLL, 1'b0, 64'hFFFF_FFFF_0000_0000});
`ifdef SHIFT_WORD_OP_EN
    vecs.push_back('{64'h0000_0000_4000_0000, 6'd1, OP_SLL, 1'b1, 64'hFFFF_FFFF_8000_0000});
    vecs.push_back('{64'h0000_0000_8000_0000, 6'h24, OP_SRA, 1'b1, 64'hFFFF_FFFF_F800_0000});
    vecs.push_back('{64'hFFFF_FFFF_8000_0000, 6'h24, OP_SRL, 1'b1, 64'h0000_0000_0800_0000});
    vecs.push_back('{64'h1234_5678_9ABC_DEF0, 6'd5, OP_PASS, 1'b1, 64'hFFFF_FFFF_9ABC_DEF0});
`endif

    // Reset values, observed while reset is held
    #2;
    chk("rst_out_valid", XLEN'(bus.out_valid), XLEN'(0));
    chk("rst_out_data", bus.out_data, XLEN'(0));
    chk("rst_out_tag", XLEN'(bus.out_tag), XLEN'(0));
    chk("rst_in_ready", XLEN'(bus.in_ready), XLEN'(1));
    #20;
    rst_n = 1'b1;
    idle(1);

    // Table: each op isolated, result exactly STAGES cycles after accept
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      send(v.data, v.amt, v.op, TAG_W'(i), v.word);
      chk("tbl_not_early", XLEN'(bus.out_valid), XLEN'(0));
      idle(1);
      chk("tbl_valid", XLEN'(bus.out_valid), XLEN'(1));
      chk("tbl_data", bus.out_data, v.exp);
      chk("tbl_tag", XLEN'(bus.out_tag), XLEN'(i));
    end
    idle(2);

    // Back-to-back with a 3-cycle output stall
    ret_tags.delete();
    bus.out_ready = 1'b0;
    fork
      begin
        for (int i = 1; i <= 4; i++)
          send({$urandom, $urandom}, SHW'($urandom_range(0, 63)), 2'($urandom_range(0, 3)), TAG_W'(i), 1'b0);
      end
      begin
        t = 0;
        do begin
          @(negedge clk);
          t++;
        end while (!bus.out_valid && t < 50);
        hd = bus.out_data;
        ht = bus.out_tag;
        chk("stall_head_tag", XLEN'(ht), XLEN'(1));
        for (int c = 0; c < 3; c++) begin
          if (c > 0) @(negedge clk);
          chk("stall_in_ready", XLEN'(bus.in_ready), XLEN'(0));
          chk("stall_valid", XLEN'(bus.out_valid), XLEN'(1));
          chk("stall_data", bus.out_data, hd);
          chk("stall_tag", XLEN'(bus.out_tag), XLEN'(ht));
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    t = 0;
    while (ret_tags.size() < 4 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("stall_ret_count", XLEN'(ret_tags.size()), XLEN'(4));
    for (int i = 0; i < ret_tags.size() && i < 4; i++)
      chk("stall_ret_order", XLEN'(ret_tags[i]), XLEN'(i + 1));
    idle(2);

    // Flush with two in flight plus a same-cycle accept
    ret_tags.delete();
    bus.out_ready = 1'b1;
    send(64'h1111, 6'd1, OP_SLL, TAG_W'(10), 1'b0);
    send(64'h2222, 6'd2, OP_SRL, TAG_W'(11), 1'b0);
    flush = 1'b1;
    send(64'h3333, 6'd3, OP_SLL, TAG_W'(12), 1'b0);
    flush = 1'b0;
    chk("flush_valid", XLEN'(bus.out_valid), XLEN'(0));
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("flush_idle_valid", XLEN'(bus.out_valid), XLEN'(0));
    end
    chk("flush_no_retire", XLEN'(ret_tags.size()), XLEN'(0));
    chk("flush_sb_empty", XLEN'(exp_q.size()), XLEN'(0));
    @(posedge clk);
    #1;
    send(64'h8000_0000_0000_0000, 6'd1, OP_SRA, TAG_W'(13), 1'b0);
    idle(1);
    chk("post_flush_valid", XLEN'(bus.out_valid), XLEN'(1));
    chk("post_flush_data", bus.out_data, 64'hC000_0000_0000_0000);
    chk("post_flush_tag", XLEN'(bus.out_tag), XLEN'(13));
    idle(2);

    // Asynchronous reset with ops in flight
    send(64'h1234_5678, 6'd0, OP_PASS, TAG_W'(20), 1'b0);
    send(64'hABCD, 6'd4, OP_SLL, TAG_W'(21), 1'b0);
    chk("pre_rst_valid", XLEN'(bus.out_valid), XLEN'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", XLEN'(bus.out_valid), XLEN'(0));
    chk("async_rst_data", bus.out_data, XLEN'(0));
    chk("async_rst_tag", XLEN'(bus.out_tag), XLEN'(0));
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("post_rst_quiet", XLEN'(bus.out_valid), XLEN'(0));
    end
    @(posedge clk);
    #1;
    send(64'hFF, 6'd4, OP_SRL, TAG_W'(22), 1'b0);
    chk("post_rst_not_early", XLEN'(bus.out_valid), XLEN'(0));
    idle(1);
    chk("post_rst_valid", XLEN'(bus.out_valid), XLEN'(1));
    chk("post_rst_data", bus.out_data, 64'hF);
    chk("post_rst_tag", XLEN'(bus.out_tag), XLEN'(22));
    idle(2);

    // Randomized traffic with random back-pressure
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
`ifdef SHIFT_WORD_OP_EN
          send({$urandom, $urandom}, SHW'($urandom_range(0, 63)), 2'($urandom_range(0, 3)),
               TAG_W'(i), 1'($urandom_range(0, 1)));
`else
          send({$urandom, $urandom}, SHW'($urandom_range(0, 63)), 2'($urandom_range(0, 3)),
               TAG_W'(i), 1'b0);
`endif
          idle($urandom_range(0, 2));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.out_ready = 1'b1;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("rand_drain_empty", XLEN'(exp_q.size()), XLEN'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
